// File: rtl/csc_blk_sched.sv
// Raster block scheduler: walks Y, then Cb, then Cr planes and issues one block per handshake.
// Optional macro CSC_SCHED_MONO_EN adds cfg_mono; when latched high the chroma planes are skipped.
module csc_blk_sched #(
    parameter int BLK_N              = 4,
    parameter int PIC_WID_IN_PIX     = 8192,
    parameter int PIC_HT_IN_PIX      = 4096,
    parameter int PIC_WID_IN_BLK     = PIC_WID_IN_PIX / BLK_N,
    parameter int PIC_HT_IN_BLK      = PIC_HT_IN_PIX / BLK_N,
    parameter int PIC_WID_IN_BLK_LEN = $clog2(PIC_WID_IN_BLK) + 1,
    parameter int PIC_HT_IN_BLK_LEN  = $clog2(PIC_HT_IN_BLK) + 1
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [PIC_WID_IN_BLK_LEN-1:0] cfg_wid_blk,
    input  logic [PIC_HT_IN_BLK_LEN-1:0]  cfg_ht_blk,
`ifdef CSC_SCHED_MONO_EN
    input  logic                          cfg_mono,
`endif
    output logic                          blk_vld,
    input  logic                          blk_rdy,
    output logic [PIC_WID_IN_BLK_LEN-1:0] blk_x,
    output logic [PIC_HT_IN_BLK_LEN-1:0]  blk_y,
    output logic [1:0]                    blk_cidx,
    output logic                          blk_last,
    output logic                          busy,
    output logic                          frm_done,
    output logic                          cfg_err
);

    localparam int WL = PIC_WID_IN_BLK_LEN;
    localparam int HL = PIC_HT_IN_BLK_LEN;
    localparam logic [WL-1:0] MAX_W = WL'(PIC_WID_IN_BLK);
    localparam logic [HL-1:0] MAX_H = HL'(PIC_HT_IN_BLK);

    typedef enum logic [2:0] {StIdle, StLuma, StCb, StCr, StDone} state_e;

    state_e        r_state, w_state_nxt, w_plane_nxt;
    logic [WL-1:0] r_x, w_x_nxt, r_wid, r_widc, w_wid_p, w_half_w, w_wid_c;
    logic [HL-1:0] r_y, w_y_nxt, r_ht, r_htc, w_ht_p, w_half_h, w_ht_c;
    logic          r_cfg_err, w_cfg_err_nxt;
    logic          w_cfg_ok, w_load, w_xfer, w_x_end, w_y_end, w_mono;

    assign w_cfg_ok = (cfg_wid_blk != '0) && (cfg_wid_blk <= MAX_W) &&
                      (cfg_ht_blk != '0) && (cfg_ht_blk <= MAX_H);
    assign w_load   = (r_state == StIdle) && start && w_cfg_ok;

    // Chroma planes are half size, never smaller than one block.
    assign w_half_w = cfg_wid_blk >> 1;
    assign w_half_h = cfg_ht_blk >> 1;
    assign w_wid_c  = (w_half_w == '0) ? WL'(1) : w_half_w;
    assign w_ht_c   = (w_half_h == '0) ? HL'(1) : w_half_h;

`ifdef CSC_SCHED_MONO_EN
    logic r_mono;
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_mono <= 1'b0;
        end else if (w_load) begin
            r_mono <= cfg_mono;
        end
    end
    assign w_mono = r_mono;
`else
    assign w_mono = 1'b0;
`endif

    assign w_wid_p = (r_state == StLuma) ? r_wid : r_widc;
    assign w_ht_p  = (r_state == StLuma) ? r_ht : r_htc;
    assign w_x_end = (r_x == w_wid_p - WL'(1));
    assign w_y_end = (r_y == w_ht_p - HL'(1));

    assign blk_vld  = (r_state == StLuma) || (r_state == StCb) || (r_state == StCr);
    assign w_xfer   = blk_vld && blk_rdy;
    assign blk_x    = r_x;
    assign blk_y    = r_y;
    assign blk_last = blk_vld && w_x_end && w_y_end;
    assign busy     = (r_state != StIdle);
    assign frm_done = (r_state == StDone);
    assign cfg_err  = r_cfg_err;

    always_comb begin
        blk_cidx    = 2'd0;
        w_plane_nxt = StDone;
        case (r_state)
            StLuma: begin
                blk_cidx    = 2'd0;
                w_plane_nxt = w_mono ? StDone : StCb;
            end
            StCb: begin
                blk_cidx    = 2'd1;
                w_plane_nxt = StCr;
            end
            StCr: begin
                blk_cidx    = 2'd2;
                w_plane_nxt = StDone;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_cfg_err_nxt = 1'b0;
        case (r_state)
            StIdle: begin
                if (start) begin
                    if (w_cfg_ok) begin
                        w_state_nxt = StLuma;
                        w_x_nxt     = '0;
                        w_y_nxt     = '0;
                    end else begin
                        w_cfg_err_nxt = 1'b1;
                    end
                end
            end
            StLuma, StCb, StCr: begin
                if (w_xfer) begin
                    if (!w_x_end) begin
                        w_x_nxt = r_x + WL'(1);
                    end else begin
                        w_x_nxt = '0;
                        if (!w_y_end) begin
                            w_y_nxt = r_y + HL'(1);
                        end else begin
                            w_y_nxt     = '0;
                            w_state_nxt = w_plane_nxt;
                        end
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
        // Abort wins over a same-cycle transfer; it is a no-op in idle.
        if (abort && (r_state != StIdle)) begin
            w_state_nxt = StIdle;
            w_x_nxt     = '0;
            w_y_nxt     = '0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= StIdle;
            r_x       <= '0;
            r_y       <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_cfg_err <= w_cfg_err_nxt;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wid  <= '0;
            r_ht   <= '0;
            r_widc <= '0;
            r_htc  <= '0;
        end else if (w_load) begin
            r_wid  <= cfg_wid_blk;
            r_ht   <= cfg_ht_blk;
            r_widc <= w_wid_c;
            r_htc  <= w_ht_c;
        end
    end

endmodule

// File: tb/tb_csc_blk_sched.sv
// Self-checking bench for csc_blk_sched: vector table, random frames vs. a queue-based model.
// Mono-plane checks are compiled in when CSC_SCHED_MONO_EN is defined.
module tb_csc_blk_sched;

    localparam int PIC_WID_IN_BLK = 8192 / 4;
    localparam int PIC_HT_IN_BLK  = 4096 / 4;
    localparam int WL = $clog2(PIC_WID_IN_BLK) + 1;
    localparam int HL = $clog2(PIC_HT_IN_BLK) + 1;

    logic          clk = 1'b0, arst_n = 1'b1, start = 1'b0, abort = 1'b0, blk_rdy = 1'b0;
    logic [WL-1:0] cfg_wid_blk = '0;
    logic [HL-1:0] cfg_ht_blk = '0;
    logic          blk_vld, blk_last, busy, frm_done, cfg_err;
    logic [WL-1:0] blk_x;
    logic [HL-1:0] blk_y;
    logic [1:0]    blk_cidx;
`ifdef CSC_SCHED_MONO_EN
    logic          cfg_mono = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    csc_blk_sched dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .start       (start),
        .abort       (abort),
        .cfg_wid_blk (cfg_wid_blk),
        .cfg_ht_blk  (cfg_ht_blk),
`ifdef CSC_SCHED_MONO_EN
        .cfg_mono    (cfg_mono),
`endif
        .blk_vld     (blk_vld),
        .blk_rdy     (blk_rdy),
        .blk_x       (blk_x),
        .blk_y       (blk_y),
        .blk_cidx    (blk_cidx),
        .blk_last    (blk_last),
        .busy        (busy),
        .frm_done    (frm_done),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w;
        int h;
        bit rnd;
        int mode;     // 0 plain, 1 abort at transfer 'at', 2 reset at 'at', 3 start poked in luma
        int at;
        int exp_len;  // hand-computed W*H + 2*Wc*Hc; -1 when the frame is cut short
    } vec_t;

    typedef struct {
        int w;
        int h;
    } bad_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input int x, input int y, input int c, input bit last);
        return (c << 24) | (int'(last) << 23) | (y << 12) | x;
    endfunction

    function automatic logic [31:0] cur_blk();
        return pack(int'(blk_x), int'(blk_y), int'(blk_cidx), blk_last);
    endfunction

    function automatic logic [31:0] all_outs();
        return {blk_vld, busy, frm_done, cfg_err, 2'b00, blk_cidx, blk_last, 1'b0,
                11'(blk_y), 12'(blk_x)} ;
    endfunction

    task automatic run_frame(input int w, input int h, input bit rnd, input bit mono,
                             input int mode, input int at, input int exp_len);
        logic [31:0] exp_q[$];
        logic [31:0] cur, held;
        int wc, hc, pw, ph, np, total, n, cyc;
        bit stalled;
        wc = ((w >> 1) == 0) ? 1 : (w >> 1);
        hc = ((h >> 1) == 0) ? 1 : (h >> 1);
        np = mono ? 1 : 3;
        for (int p = 0; p < np; p++) begin
            pw = (p == 0) ? w : wc;
            ph = (p == 0) ? h : hc;
            for (int y = 0; y < ph; y++)
                for (int x = 0; x < pw; x++)
                    exp_q.push_back(pack(x, y, p, (x == pw - 1) && (y == ph - 1)));
        end
        total = exp_q.size();
        if (exp_len < 0) exp_len = total;

        @(negedge clk);
        cfg_wid_blk = WL'(w);
        cfg_ht_blk  = HL'(h);
`ifdef CSC_SCHED_MONO_EN
        cfg_mono    = mono;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Later config changes must not matter.
        cfg_wid_blk = WL'($urandom_range(1, 7));
        cfg_ht_blk  = HL'($urandom_range(1, 7));
        check("vld_after_start", {31'd0, blk_vld}, 32'd1);

        n = 0;
        cyc = 0;
        stalled = 1'b0;
        held = '0;
        while (exp_q.size() > 0) begin
            if (cyc > 20 * total + 100) begin
                check("frame_timeout", n, total);
                break;
            end
            cur = cur_blk();
            check("vld_hold", {31'd0, blk_vld}, 32'd1);
            if (stalled) check("stall_stable", cur, held);
            if (mode == 1 && n == at) begin
                abort   = 1'b1;
                blk_rdy = 1'b1;
                @(negedge clk);
                abort   = 1'b0;
                blk_rdy = 1'b0;
                check("abort_vld", {31'd0, blk_vld}, 32'd0);
                check("abort_busy", {31'd0, busy}, 32'd0);
                repeat (3) begin
                    @(negedge clk);
                    check("abort_no_done", {30'd0, frm_done, busy}, 32'd0);
                end
                return;
            end
            if (mode == 2 && n == at) begin
                arst_n = 1'b0;
                #1;
                check("reset_outs", all_outs(), 32'd0);
                @(negedge clk);
                check("reset_hold", all_outs(), 32'd0);
                arst_n = 1'b1;
                @(negedge clk);
                check("reset_idle", all_outs(), 32'd0);
                return;
            end
            start = (mode == 3) && (exp_q[0][25:24] == 2'd0);
            if (start) begin
                cfg_wid_blk = WL'(1);
                cfg_ht_blk  = HL'(1);
            end
            blk_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (blk_rdy) begin
                check("xfer", cur, exp_q.pop_front());
                n++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held = cur;
            end
            @(negedge clk);
            cyc++;
        end
        blk_rdy = 1'b0;
        start   = 1'b0;
        check("xfer_count", n, exp_len);
        if (!rnd) check("cycles_per_frame", cyc, total);
        check("frm_done", {31'd0, frm_done}, 32'd1);
        check("done_vld", {31'd0, blk_vld}, 32'd0);
        @(negedge clk);
        check("done_pulse", {30'd0, frm_done, busy}, 32'd0);
    endtask

    task automatic bad_start(input int w, input int h);
        @(negedge clk);
        cfg_wid_blk = WL'(w);
        cfg_ht_blk  = HL'(h);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("cfg_err_pulse", {29'd0, cfg_err, busy, blk_vld}, 32'h4);
        @(negedge clk);
        check("cfg_err_clear", {29'd0, cfg_err, busy, blk_vld}, 32'h0);
    endtask

    vec_t vecs[9];
    bad_t bads[5];

    initial begin
        vecs[0] = '{w: 4,    h: 2,    rnd: 0, mode: 0, at: 0,  exp_len: 12};
        vecs[1] = '{w: 3,    h: 3,    rnd: 1, mode: 0, at: 0,  exp_len: 11};
        vecs[2] = '{w: 1,    h: 1,    rnd: 0, mode: 0, at: 0,  exp_len: 3};
        vecs[3] = '{w: 4,    h: 2,    rnd: 1, mode: 1, at: 9,  exp_len: -1};
        vecs[4] = '{w: 4,    h: 2,    rnd: 0, mode: 0, at: 0,  exp_len: 12};
        vecs[5] = '{w: 4,    h: 2,    rnd: 1, mode: 3, at: 0,  exp_len: 12};
        vecs[6] = '{w: 4,    h: 2,    rnd: 0, mode: 2, at: 11, exp_len: -1};
        vecs[7] = '{w: 2048, h: 1,    rnd: 0, mode: 0, at: 0,  exp_len: 4096};
        vecs[8] = '{w: 1,    h: 1024, rnd: 1, mode: 0, at: 0,  exp_len: 2048};
        bads[0] = '{w: 0,    h: 2};
        bads[1] = '{w: 3,    h: 0};
        bads[2] = '{w: 2049, h: 1};
        bads[3] = '{w: 4,    h: 1025};
        bads[4] = '{w: 0,    h: 0};

        #2 arst_n = 1'b0;
        #1 check("reset_state", all_outs(), 32'd0);
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", all_outs(), 32'd0);

        foreach (bads[i]) bad_start(bads[i].w, bads[i].h);

        foreach (vecs[i])
            run_frame(vecs[i].w, vecs[i].h, vecs[i].rnd, 1'b0, vecs[i].mode, vecs[i].at,
                      vecs[i].exp_len);

        for (int i = 0; i < 6; i++)
            run_frame($urandom_range(1, 9), $urandom_range(1, 7), 1'b1, 1'b0, 0, 0, -1);

`ifdef CSC_SCHED_MONO_EN
        run_frame(2, 2, 1'b0, 1'b1, 0, 0, 4);
        run_frame(2, 2, 1'b0, 1'b0, 0, 0, 6);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/csc_blk_sched.md
Name: csc_blk_sched

Overview:
- Frame-level block scheduler for the compressed-sensing intra encoder.
- Walks a picture in raster block order: luma plane (cIdx 0) first, then Cb (cIdx 1), then Cr (cIdx 2).
- Issues one block coordinate per valid/ready handshake to the measurement/prediction datapath.
- Picture size is configured at run time in blocks, up to the compile-time maximum; start, abort and frame-done control.

Parameters:
- BLK_N, 4, block edge in pixels (documentation only; no logic depends on it).
- PIC_WID_IN_PIX, 8192, maximum picture width in pixels.
- PIC_HT_IN_PIX, 4096, maximum picture height in pixels.
- PIC_WID_IN_BLK, PIC_WID_IN_PIX/BLK_N, maximum width in blocks.
- PIC_HT_IN_BLK, PIC_HT_IN_PIX/BLK_N, maximum height in blocks.
- PIC_WID_IN_BLK_LEN, $clog2(PIC_WID_IN_BLK)+1, width of the X/config width fields.
- PIC_HT_IN_BLK_LEN, $clog2(PIC_HT_IN_BLK)+1, width of the Y/config height fields.

Ports:
- clk  in  1  clock; all logic on posedge.
- arst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle frame start request; honoured only in IDLE.
- abort  in  1  synchronous frame abort.
- cfg_wid_blk  in  PIC_WID_IN_BLK_LEN  luma width in blocks; legal range 1..PIC_WID_IN_BLK.
- cfg_ht_blk  in  PIC_HT_IN_BLK_LEN  luma height in blocks; legal range 1..PIC_HT_IN_BLK.
- blk_vld  out  1  block coordinate valid.
- blk_rdy  in  1  datapath accepts the block.
- blk_x  out  PIC_WID_IN_BLK_LEN  block column.
- blk_y  out  PIC_HT_IN_BLK_LEN  block row.
- blk_cidx  out  2  component index: 0 = Y, 1 = Cb, 2 = Cr.
- blk_last  out  1  current block is the last block of its plane.
- busy  out  1  high in any state other than IDLE.
- frm_done  out  1  one-cycle pulse when a frame completes.
- cfg_err  out  1  one-cycle pulse when start is rejected for an illegal config.

Behaviour:
- Reset: state IDLE; all outputs 0; internal width/height registers 0.
- States: IDLE, LUMA, CB, CR, DONE.
- IDLE + start + legal config:
  - Latch W = cfg_wid_blk, H = cfg_ht_blk.
  - Chroma size: Wc = max(1, W>>1), Hc = max(1, H>>1).
  - Next cycle: state LUMA, blk_vld=1, x=y=0, cidx=0.
- IDLE + start + illegal config (zero, or above maximum): stay in IDLE; cfg_err pulses the next cycle.
- Handshake:
  - A transfer occurs on a cycle with blk_vld && blk_rdy.
  - While blk_vld && !blk_rdy, blk_x, blk_y, blk_cidx and blk_last hold stable.
  - blk_vld never drops without a transfer, except on abort or reset.
- Advance on each transfer:
  - If x < Wp-1: x+1.
  - Else x=0; then if y < Hp-1: y+1, else the plane ends.
  - Wp/Hp are the sizes of the current plane.
- Plane end: LUMA -> CB, CB -> CR, CR -> DONE. x and y reset to 0. blk_vld stays 1 into CB/CR, giving back-to-back issue with no bubble.
- DONE: blk_vld=0, frm_done=1 for exactly one cycle, then IDLE.
- Throughput: one block per cycle while blk_rdy=1. Frame length = W*H + 2*Wc*Hc transfers.
- blk_last: combinational from registered x, y and current plane size; equals (x==Wp-1 && y==Hp-1) while blk_vld.
- abort:
  - In any state: next state IDLE, blk_vld=0, no frm_done.
  - Abort has priority over a simultaneous transfer.
  - Abort in IDLE has no effect.
- start while busy is ignored; it is not queued.
- Config inputs are sampled only at the accepted start; later changes during a frame have no effect.
- 1x1 picture: Wc=Hc=1, giving 3 transfers, each with blk_last=1.
- Asynchronous reset mid-frame: immediate return to the reset values.

Optional Feature:
- Macro: CSC_SCHED_MONO_EN.
- When defined:
  - Adds input cfg_mono (1 bit), latched at start.
  - If the latched value is 1, LUMA plane end goes straight to DONE; Cb/Cr are never issued.
- When undefined: no cfg_mono port; chroma planes are always issued.

Test Plan:
- W=4, H=2, blk_rdy=1: start -> 8 luma + 2 Cb + 2 Cr transfers, one per cycle. Order (0,0)..(3,0),(0,1)..(3,1); then cidx 1 (0,0),(1,0); then cidx 2 (0,0),(1,0). blk_last on the 8th, 10th and 12th transfer. frm_done one cycle after the 12th.
- Backpressure: W=3, H=3 with blk_rdy toggling at random -> coordinates are stable while stalled. Exactly 9+1+1 transfers in correct order.
- cfg_wid_blk=0 or cfg_ht_blk=PIC_HT_IN_BLK+1 at start -> cfg_err pulse, busy stays 0, blk_vld stays 0.
- Abort during CB after 1 transfer -> blk_vld=0 next cycle, IDLE, no frm_done. A following start runs the full frame again from luma (0,0).
- start asserted during LUMA -> ignored; frame count and order unchanged. Reset asserted mid-CR -> all outputs 0 immediately.
- With CSC_SCHED_MONO_EN, cfg_mono=1, W=2, H=2 -> 4 luma transfers, then frm_done; no cidx 1/2 transfers.
